// File: rtl/mux_stream_pkg.sv
// Shared types and the round-robin search helper for the N:1 stream mux.
// rr_pick scans from ptr+1 upward, wrapping at n, and returns the first set bit.
package mux_stream_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int SLICE_W_DEF = 2;
  localparam int MAX_CH      = 64;
  localparam int CH_ID_W     = 6;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   found;
    ch_id_t idx;
  } rr_pick_t;

  // Walk candidates farthest-first so the nearest valid channel wins last.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] valid,
                                       input ch_id_t ptr,
                                       input int n);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n) begin
        cand = int'(ptr) + k;
        if (cand >= n) cand = cand - n;
        if (valid[cand]) begin
          res.found = 1'b1;
          res.idx   = ch_id_t'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_n_1_slice.sv
// N_CH:1 combinational mux of one SLICE_W-wide slice; out-of-range select yields zero.
module mux_n_1_slice #(
  parameter int N_CH    = 4,
  parameter int SLICE_W = 2
) (
  input  logic [$clog2(N_CH)-1:0]  sel,
  input  logic [N_CH*SLICE_W-1:0]  in_slices,
  output logic [SLICE_W-1:0]       out_slice
);

  always_comb begin
    out_slice = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(sel) == c) out_slice = in_slices[c*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/mux_n_1_stream_rr.sv
// N_CH:1 valid/ready stream mux with explicit-select or round-robin grant and one
// registered output stage; drain and accept may happen in the same cycle.
module mux_n_1_stream_rr
  import mux_stream_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int SEL_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arb_en,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch
);

  localparam int N_SLICE = DATA_W / SLICE_W;

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic              load_en;
  logic              xfer;
  rr_pick_t          pick;
  logic [DATA_W-1:0] mux_data;

  assign load_en = !out_valid || out_ready;

  always_comb begin
    pick        = rr_pick(MAX_CH'(in_valid), ch_id_t'(rr_ptr), N_CH);
    grant       = '0;
    grant_valid = 1'b0;
    if (arb_en) begin
      grant_valid = pick.found && (int'(pick.idx) < N_CH);
      grant       = SEL_W'(pick.idx);
    end else begin
      grant_valid = int'(sel) < N_CH;
      grant       = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = load_en && grant_valid && (int'(grant) == i);
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Every slice shares the grant index, so the word is assembled coherently.
  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [N_CH*SLICE_W-1:0] slice_in;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign slice_in[c*SLICE_W +: SLICE_W] = in_data[c*DATA_W + s*SLICE_W +: SLICE_W];
    end
    mux_n_1_slice #(
      .N_CH    (N_CH),
      .SLICE_W (SLICE_W)
    ) u_slice (
      .sel       (grant),
      .in_slices (slice_in),
      .out_slice (mux_data[s*SLICE_W +: SLICE_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_ch    <= grant;
      rr_ptr    <= grant;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_1_stream_rr.sv
// Directed bench for the N:1 stream mux: a 4x8/2 instance and a 3x12/4 instance.
module tb_mux_n_1_stream_rr;

  logic clk;
  logic rst_n;

  logic        a_arb_en;
  logic [1:0]  a_sel;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [31:0] a_in_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;

  logic        b_arb_en;
  logic [1:0]  b_sel;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [35:0] b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [11:0] b_out_data;
  logic [1:0]  b_out_ch;

  int checks = 0;
  int errors = 0;

  mux_n_1_stream_rr #(.N_CH(4), .DATA_W(8), .SLICE_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .arb_en(a_arb_en), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ch(a_out_ch)
  );

  mux_n_1_stream_rr #(.N_CH(3), .DATA_W(12), .SLICE_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .arb_en(b_arb_en), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ch(b_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_in_valid = '0;
    b_in_valid = '0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_arb_en    = 1'b0;
    a_sel       = '0;
    a_in_valid  = '0;
    a_in_data   = '0;
    a_out_ready = 1'b0;
    b_arb_en    = 1'b0;
    b_sel       = '0;
    b_in_valid  = '0;
    b_in_data   = '0;
    b_out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_data", 32'(a_out_data), 0);
    check("rst_out_ch", 32'(a_out_ch), 0);
    rst_n = 1'b1;

    // 1: explicit select of channel 2
    a_sel       = 2'd2;
    a_in_valid  = 4'b0100;
    a_in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    a_out_ready = 1'b1;
    #1;
    check("t1_in_ready", 32'(a_in_ready), 32'h4);
    tick();
    a_in_valid = '0;
    check("t1_out_valid", 32'(a_out_valid), 1);
    check("t1_out_data", 32'(a_out_data), 32'hA5);
    check("t1_out_ch", 32'(a_out_ch), 2);

    // 2: round-robin over four always-valid channels
    do_reset();
    a_arb_en   = 1'b1;
    a_in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    a_in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t2_in_ready", 32'(a_in_ready), 32'(1 << (k % 4)));
      tick();
      check("t2_out_valid", 32'(a_out_valid), 1);
      check("t2_out_ch", 32'(a_out_ch), 32'(k % 4));
      check("t2_out_data", 32'(a_out_data), 32'(8'h10 + k % 4));
    end
    a_in_valid = '0;
    tick();
    check("t2_drain_valid", 32'(a_out_valid), 0);

    // 3: round-robin over channels 1 and 3
    do_reset();
    a_in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_in_ready", 32'(a_in_ready), 32'(1 << ((k % 2 == 1) ? 3 : 1)));
      tick();
      check("t3_out_ch", 32'(a_out_ch), 32'((k % 2 == 1) ? 3 : 1));
    end

    // 4: consumer stall, then drain and accept together
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall_in_ready", 32'(a_in_ready), 0);
      tick();
      check("t4_stall_valid", 32'(a_out_valid), 1);
      check("t4_stall_data", 32'(a_out_data), 32'h13);
      check("t4_stall_ch", 32'(a_out_ch), 3);
    end
    a_out_ready = 1'b1;
    #1;
    check("t4_resume_in_ready", 32'(a_in_ready), 32'h2);
    tick();
    check("t4_resume_valid", 32'(a_out_valid), 1);
    check("t4_resume_ch", 32'(a_out_ch), 1);
    check("t4_resume_data", 32'(a_out_data), 32'h11);
    a_in_valid = '0;

    // 5: three-channel, 12-bit build with 4-bit slices
    b_in_data   = {12'h456, 12'hABC, 12'h123};
    b_out_ready = 1'b1;
    b_sel       = 2'd1;
    b_in_valid  = 3'b010;
    #1;
    check("t5_in_ready_ch1", 32'(b_in_ready), 32'h2);
    tick();
    check("t5_data_ch1", 32'(b_out_data), 32'hABC);
    check("t5_ch_ch1", 32'(b_out_ch), 1);
    b_sel      = 2'd2;
    b_in_valid = 3'b100;
    tick();
    check("t5_data_ch2", 32'(b_out_data), 32'h456);
    check("t5_valid_ch2", 32'(b_out_valid), 1);
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    #1;
    check("t5_sel3_in_ready", 32'(b_in_ready), 0);
    tick();
    check("t5_sel3_valid", 32'(b_out_valid), 0);
    check("t5_sel3_data_hold", 32'(b_out_data), 32'h456);
    b_in_valid = '0;

    // 6: asynchronous reset while the output holds a word
    a_in_valid = 4'b1111;
    tick();
    tick();
    check("t6_pre_valid", 32'(a_out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(a_out_valid), 0);
    check("t6_async_data", 32'(a_out_data), 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("t6_first_in_ready", 32'(a_in_ready), 32'h1);
    tick();
    check("t6_first_ch", 32'(a_out_ch), 0);
    check("t6_first_data", 32'(a_out_data), 32'h10);
    a_in_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
